// File: rtl/mem_if_pkg.sv
// Shared definitions for the slow-memory line interface.
//   LINE_ADDR_W : line address width (byte address bits [31:4])
//   LINE_W      : line data width
//   state_t     : request sequencer states IDLE / ISSUE / DONE
//   CLI_I/CLI_D : client indices (0 = I-side, 1 = D-side)
package mem_if_pkg;
  localparam int LINE_ADDR_W = 28;
  localparam int LINE_W      = 128;

  localparam int CLI_I = 0;
  localparam int CLI_D = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/mem_req_initiator_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
// Ports:
//   req[1:0]   : request vector, bit i = client i
//   rr_last    : index of the client that won the previous arbitration
//   grant[1:0] : one-hot grant (all zero when nothing requests)
// A lone requester always wins; on a tie the client that did not win last
// time is granted.
module rr_arb2
  import mem_if_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req[CLI_I] && (!req[CLI_D] || rr_last == 1'(CLI_D))) begin
      grant[CLI_I] = 1'b1;
    end else if (req[CLI_D]) begin
      grant[CLI_D] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_req_initiator.sv
// mem_req_initiator: initiator side of the slow-memory line protocol.
// Arbitrates line reads/writes from two cache clients (0 = I-side,
// 1 = D-side) and runs one transaction at a time on the memory port.
// Sequence per transaction: IDLE (arbitrate + latch) -> ISSUE (strobe held
// until mem_ready) -> DONE (one-cycle ack to the winner) -> IDLE.
//
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   cX_req/cX_we/cX_addr/cX_wdata   : client X request, write flag, line
//                                     address, write line
//   cX_ack/cX_rdata                 : client X done pulse, read line
//                                     (held until the next ack to X)
//   mem_read/mem_write              : memory strobes, never both high
//   mem_addr/mem_wdata              : memory line address / write line
//   mem_rdata/mem_ready             : memory read line / completion pulse
//   busy                            : high in ISSUE and DONE
//   err                             : sticky timeout flag
//
// Build option: define MEM_TIMEOUT_EN to add the ISSUE watchdog. A timed-out
// transaction is acked with rdata = 0 and err is set until reset. Without
// the macro err is tied low and ISSUE waits for mem_ready indefinitely.
module mem_req_initiator #(
  parameter int ADDR_W  = mem_if_pkg::LINE_ADDR_W,
  parameter int LINE_W  = mem_if_pkg::LINE_W,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c0_req,
  input  logic              c0_we,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [LINE_W-1:0] c0_wdata,
  output logic              c0_ack,
  output logic [LINE_W-1:0] c0_rdata,
  input  logic              c1_req,
  input  logic              c1_we,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [LINE_W-1:0] c1_wdata,
  output logic              c1_ack,
  output logic [LINE_W-1:0] c1_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              err
);
  import mem_if_pkg::*;

  state_t              state_q, state_d;
  logic                rr_last_q;
  logic                win_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LINE_W-1:0]   wdata_q;
  logic [LINE_W-1:0]   c0_rdata_q, c1_rdata_q;
  logic [1:0]          req, grant;
  logic                latch_en;
  logic                timeout_hit;
  logic                issue_end;
  logic [LINE_W-1:0]   line_in;

  assign req = {c1_req, c0_req};

  rr_arb2 u_arb (
    .req     (req),
    .rr_last (rr_last_q),
    .grant   (grant)
  );

`ifdef MEM_TIMEOUT_EN
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

  logic [9:0] tmo_cnt_q;
  logic       err_q;

  // The counter sits at zero outside ISSUE, so every ISSUE starts from 0.
  // The limit is hit on the TIMEOUT-th ISSUE cycle without mem_ready.
  assign timeout_hit = (state_q == ISSUE) && !mem_ready && (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state_q != ISSUE) begin
        tmo_cnt_q <= '0;
      end else if (!mem_ready) begin
        tmo_cnt_q <= tmo_cnt_q + 10'd1;
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  assign issue_end = (state_q == ISSUE) && (mem_ready || timeout_hit);
  assign line_in   = timeout_hit ? '0 : mem_rdata;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and outputs. Strobes decode straight from the state register
  // so an async reset removes them without waiting for a clock.
  always_comb begin
    state_d   = state_q;
    latch_en  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    busy      = 1'b0;
    c0_ack    = 1'b0;
    c1_ack    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          latch_en = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        busy      = 1'b1;
        mem_read  = ~we_q;
        mem_write = we_q;
        if (issue_end) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        c0_ack  = (win_q == 1'(CLI_I));
        c1_ack  = (win_q == 1'(CLI_D));
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch and per-client read-line holding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q  <= 1'b1;
      win_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      c0_rdata_q <= '0;
      c1_rdata_q <= '0;
    end else begin
      if (latch_en) begin
        win_q     <= grant[CLI_D];
        rr_last_q <= grant[CLI_D];
        if (grant[CLI_D]) begin
          we_q    <= c1_we;
          addr_q  <= c1_addr;
          wdata_q <= c1_wdata;
        end else if (grant[CLI_I]) begin
          we_q    <= c0_we;
          addr_q  <= c0_addr;
          wdata_q <= c0_wdata;
        end
      end
      // Writes leave the client's read line alone unless they timed out.
      if (issue_end && (!we_q || timeout_hit)) begin
        if (win_q == 1'(CLI_D)) begin
          c1_rdata_q <= line_in;
        end else begin
          c0_rdata_q <= line_in;
        end
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign c0_rdata  = c0_rdata_q;
  assign c1_rdata  = c1_rdata_q;

endmodule
